// File: rtl/dice_pkg.sv
// Shared types and constants for the dice roll controller.
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROLL,
    SETTLE,
    SHOW
  } dice_state_t;

  typedef logic [2:0] face_t;

  localparam face_t FACE_BLANK = 3'b000;

  // Length in cycles of settle step k: the interval doubles on every step.
  function automatic int unsigned settle_len(input int unsigned tick_div, input int unsigned k);
    return tick_div << (k + 1);
  endfunction

endpackage

// File: rtl/dice_roll_controller_if.sv
// Button-in / face-out bundle between the board, the dice controller and the pip decoder.
interface dice_roll_controller_if;
  import dice_pkg::*;

  logic  roll;
  face_t face;
  logic  busy;
  logic  result_valid;
  logic  done;

  modport master (
    output roll,
    input  face, busy, result_valid, done
  );

  modport slave (
    input  roll,
    output face, busy, result_valid, done
  );

endinterface

// File: rtl/dice_input_sync.sv
// Two-flop synchronizer for the raw roll button plus a rising-edge detect.
module dice_input_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic roll,
  output logic roll_s,
  output logic roll_rise
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= roll;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign roll_s    = sync;
  assign roll_rise = sync & ~sync_d;

endmodule

// File: rtl/dice_roll_controller.sv
// Roll / settle / show sequencer driving the eight_dice face select.
// Define DICE_AUTO_BLANK_EN to blank the display BLANK_CYCLES cycles after a result is shown.
module dice_roll_controller
  import dice_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 2_500_000,
  parameter int unsigned SETTLE_STEPS = 4,
  parameter int unsigned BLANK_CYCLES = 250_000_000
) (
  input logic                    clk,
  input logic                    rst_n,
  dice_roll_controller_if.slave  bus
);

  localparam int unsigned CW        = $clog2(TICK_DIV << SETTLE_STEPS);
  localparam logic [CW-1:0] ROLL_LAST = CW'(TICK_DIV - 1);
  localparam logic [2:0]    LAST_STEP = 3'(SETTLE_STEPS - 1);

  if (TICK_DIV < 2 || SETTLE_STEPS < 1 || SETTLE_STEPS > 8 || BLANK_CYCLES < 1) begin : g_bad_param
    $error("dice_roll_controller: illegal parameter value");
  end

  logic          roll_s;
  logic          roll_rise;
  dice_state_t   state;
  face_t         face;
  logic [CW-1:0] cnt;
  logic [CW-1:0] settle_last;
  logic [2:0]    step;
  logic          done;

  dice_input_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .roll      (bus.roll),
    .roll_s    (roll_s),
    .roll_rise (roll_rise)
  );

  always_comb begin
    settle_last = CW'(settle_len(TICK_DIV, 32'(step)) - 1);
  end

`ifdef DICE_AUTO_BLANK_EN
  localparam int unsigned BW = $clog2(BLANK_CYCLES + 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
  logic [BW-1:0] bcnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      face  <= FACE_BLANK;
      cnt   <= '0;
      step  <= '0;
      done  <= 1'b0;
`ifdef DICE_AUTO_BLANK_EN
      bcnt  <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (roll_rise) begin
            state <= ROLL;
            cnt   <= '0;
          end
        end
        ROLL: begin
          // A period completing on the release edge still counts; only a partial one is dropped.
          if (cnt == ROLL_LAST) begin
            cnt  <= '0;
            face <= face + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
          if (!roll_s) begin
            state <= SETTLE;
            cnt   <= '0;
            step  <= '0;
          end
        end
        SETTLE: begin
          if (cnt == settle_last) begin
            cnt  <= '0;
            face <= face + 3'd1;
            step <= step + 3'd1;
            if (step == LAST_STEP) begin
              state <= SHOW;
              done  <= 1'b1;
`ifdef DICE_AUTO_BLANK_EN
              bcnt  <= '0;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHOW: begin
          if (roll_rise) begin
            state <= ROLL;
            cnt   <= '0;
          end
`ifdef DICE_AUTO_BLANK_EN
          else if (bcnt == BLANK_LAST) begin
            state <= IDLE;
            face  <= FACE_BLANK;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.face         = face;
  assign bus.busy         = (state == ROLL) || (state == SETTLE);
  assign bus.result_valid = (state == SHOW);
  assign bus.done         = done;

endmodule

// File: tb/tb_dice_roll_controller.sv
// Directed bench for dice_roll_controller with TICK_DIV=4, SETTLE_STEPS=3, BLANK_CYCLES=20.
module tb_dice_roll_controller;
  import dice_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  dice_roll_controller_if bus ();

  dice_roll_controller #(
    .TICK_DIV     (4),
    .SETTLE_STEPS (3),
    .BLANK_CYCLES (20)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Measurements from one press/release sequence; k counts negedges after release.
  int    m_done_k;
  int    m_done_cnt;
  face_t m_face_done;
  logic  m_rv_done;
  logic  m_busy_done;
  logic  m_busy2, m_busy3, m_rv2, m_rv3;
  face_t m_face3;
  face_t m_face_exit;
  face_t m_face_s1;
  logic  m_done60, m_busy60;
  face_t m_face60;

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_roll(input int hold, input int pulse_at);
    m_done_k   = -1;
    m_done_cnt = 0;
    @(negedge clk);
    bus.roll = 1'b1;
    @(negedge clk);
    @(negedge clk);
    m_busy2 = bus.busy;
    m_rv2   = bus.result_valid;
    @(negedge clk);
    m_busy3 = bus.busy;
    m_rv3   = bus.result_valid;
    m_face3 = bus.face;
    repeat (hold - 3) @(negedge clk);
    bus.roll = 1'b0;
    for (int k = 1; k <= 62; k++) begin
      @(negedge clk);
      if (bus.done) begin
        m_done_cnt++;
        if (m_done_k < 0) begin
          m_done_k    = k;
          m_face_done = bus.face;
          m_rv_done   = bus.result_valid;
          m_busy_done = bus.busy;
        end
      end
      if (k == 3)  m_face_exit = bus.face;
      if (k == 11) m_face_s1   = bus.face;
      if (k == 60) begin
        m_done60 = bus.done;
        m_busy60 = bus.busy;
        m_face60 = bus.face;
      end
      if (pulse_at > 0 && k == pulse_at)     bus.roll = 1'b1;
      if (pulse_at > 0 && k == pulse_at + 3) bus.roll = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    bus.roll = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (bus.face !== 3'd0) begin errors++; $display("FAIL reset_face got %0d want 0", bus.face); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL reset_rv got %b want 0", bus.result_valid); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    bus.roll = 1'b0;
    rst_n    = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle busy got %b want 0", bus.busy); end
  endtask

  task automatic test_basic();
    do_roll(10, 0);
    checks++; if (m_busy2 !== 1'b0) begin errors++; $display("FAIL basic_busy_e1 got %b want 0", m_busy2); end
    checks++; if (m_busy3 !== 1'b1) begin errors++; $display("FAIL basic_busy_e2 got %b want 1", m_busy3); end
    checks++; if (m_face_exit !== 3'd2) begin errors++; $display("FAIL basic_roll_face got %0d want 2", m_face_exit); end
    checks++; if (m_face_s1 !== 3'd3) begin errors++; $display("FAIL basic_settle1_face got %0d want 3", m_face_s1); end
    checks++; if (m_done_k !== 59) begin errors++; $display("FAIL basic_done_time got %0d want 59", m_done_k); end
    checks++; if (m_done_cnt !== 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", m_done_cnt); end
    checks++; if (m_face_done !== 3'd5) begin errors++; $display("FAIL basic_face got %0d want 5", m_face_done); end
    checks++; if (m_rv_done !== 1'b1) begin errors++; $display("FAIL basic_rv_with_done got %b want 1", m_rv_done); end
    checks++; if (m_busy_done !== 1'b0) begin errors++; $display("FAIL basic_busy_show got %b want 0", m_busy_done); end
    checks++; if (m_done60 !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b want 0", m_done60); end
    checks++; if (m_face60 !== 3'd5) begin errors++; $display("FAIL basic_face_held got %0d want 5", m_face60); end
  endtask

  task automatic test_reroll_from_show();
    do_roll(8, 0);
    checks++; if (m_rv2 !== 1'b1) begin errors++; $display("FAIL reroll_rv_e1 got %b want 1", m_rv2); end
    checks++; if (m_rv3 !== 1'b0) begin errors++; $display("FAIL reroll_rv_e2 got %b want 0", m_rv3); end
    checks++; if (m_busy3 !== 1'b1) begin errors++; $display("FAIL reroll_busy got %b want 1", m_busy3); end
    checks++; if (m_face3 !== 3'd5) begin errors++; $display("FAIL reroll_start_face got %0d want 5", m_face3); end
    checks++; if (m_face_exit !== 3'd7) begin errors++; $display("FAIL reroll_roll_face got %0d want 7", m_face_exit); end
    checks++; if (m_face_done !== 3'd2) begin errors++; $display("FAIL reroll_face got %0d want 2", m_face_done); end
    checks++; if (m_done_cnt !== 1) begin errors++; $display("FAIL reroll_done_count got %0d want 1", m_done_cnt); end
  endtask

  task automatic test_show_hold();
`ifdef DICE_AUTO_BLANK_EN
    repeat (16) @(negedge clk);
    checks++; if (bus.result_valid !== 1'b1) begin errors++; $display("FAIL blank_early_rv got %b want 1", bus.result_valid); end
    checks++; if (bus.face !== 3'd2) begin errors++; $display("FAIL blank_early_face got %0d want 2", bus.face); end
    @(negedge clk);
    checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL blank_rv got %b want 0", bus.result_valid); end
    checks++; if (bus.face !== 3'd0) begin errors++; $display("FAIL blank_face got %0d want 0", bus.face); end
`else
    repeat (100) @(negedge clk);
    checks++; if (bus.result_valid !== 1'b1) begin errors++; $display("FAIL hold_rv got %b want 1", bus.result_valid); end
    checks++; if (bus.face !== 3'd2) begin errors++; $display("FAIL hold_face got %0d want 2", bus.face); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL hold_busy got %b want 0", bus.busy); end
`endif
  endtask

  task automatic test_settle_press();
    reset_dut();
    do_roll(10, 20);
    checks++; if (m_face_done !== 3'd5) begin errors++; $display("FAIL settle_press_face got %0d want 5", m_face_done); end
    checks++; if (m_done_k !== 59) begin errors++; $display("FAIL settle_press_time got %0d want 59", m_done_k); end
    checks++; if (m_busy60 !== 1'b0) begin errors++; $display("FAIL settle_press_busy got %b want 0", m_busy60); end
  endtask

  task automatic test_wrap();
    reset_dut();
    do_roll(28, 0);
    checks++; if (m_face_exit !== 3'd7) begin errors++; $display("FAIL wrap_roll_face got %0d want 7", m_face_exit); end
    checks++; if (m_face_done !== 3'd2) begin errors++; $display("FAIL wrap_face got %0d want 2", m_face_done); end
    checks++; if (m_done_k !== 59) begin errors++; $display("FAIL wrap_done_time got %0d want 59", m_done_k); end
  endtask

  task automatic test_reset_mid_settle();
    int dcount;
    reset_dut();
    @(negedge clk);
    bus.roll = 1'b1;
    repeat (10) @(negedge clk);
    bus.roll = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midsettle_busy got %b want 1", bus.busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL async_busy got %b want 0", bus.busy); end
    checks++; if (bus.face !== 3'd0) begin errors++; $display("FAIL async_face got %0d want 0", bus.face); end
    checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL async_rv got %b want 0", bus.result_valid); end
    @(negedge clk);
    rst_n  = 1'b1;
    dcount = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.done) dcount++;
    end
    checks++; if (dcount !== 0) begin errors++; $display("FAIL async_no_done got %0d want 0", dcount); end
    checks++; if (bus.face !== 3'd0) begin errors++; $display("FAIL async_idle_face got %0d want 0", bus.face); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    bus.roll = 1'b0;
    test_reset();
    test_basic();
    test_reroll_from_show();
    test_show_hold();
    test_settle_press();
    test_wrap();
    test_reset_mid_settle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
